mcycle_arbiter: RTL and testbench

//  Shares one MCycle multiply/divide unit between two requesters (Req0, Req1).

---
 rtl/mcycle_arbiter.sv | 139 +++++++++++++
 tb/tb_mcycle_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_arbiter.sv
// Round-robin share of one MCycle unit between two requesters: Ack the cycle after grant,
// Done/Err one cycle after MCycle drops Busy or the WAIT timeout expires; no grant outside IDLE.
module mcycle_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [1:0]       Op0,
  input  logic [1:0]       Op1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  output logic             Ack0,
  output logic             Ack1,
  output logic             Done0,
  output logic             Done1,
  output logic             Err,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             MC_Start,
  output logic [1:0]       MC_Op,
  output logic [WIDTH-1:0] MC_A,
  output logic [WIDTH-1:0] MC_B,
  input  logic [WIDTH-1:0] MC_Result1,
  input  logic [WIDTH-1:0] MC_Result2,
  input  logic             MC_Busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          rr;        // id granted last; the other side wins a tie
  logic          winner;    // id of the operation in flight
  logic          grant;
  logic          grant_id;
  logic          finish;
  logic          abort;
  logic [CW-1:0] tmo_cnt;

  assign grant_id = (Req0 & Req1) ? ~rr : Req1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    MC_Start  = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 | Req1) begin
          grant     = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        MC_Start = 1'b1;
        if (MC_Busy) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A completing MCycle wins over a timeout landing on the same edge.
        if (!MC_Busy) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else if (tmo_cnt >= TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rr      <= 1'b1;
      winner  <= 1'b0;
      MC_Op   <= '0;
      MC_A    <= '0;
      MC_B    <= '0;
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      Done0   <= 1'b0;
      Done1   <= 1'b0;
      Err     <= 1'b0;
      Result1 <= '0;
      Result2 <= '0;
      tmo_cnt <= '0;
    end else begin
      Ack0  <= grant & ~grant_id;
      Ack1  <= grant & grant_id;
      Done0 <= (finish | abort) & ~winner;
      Done1 <= (finish | abort) & winner;
      Err   <= abort;

      if (grant) begin
        rr      <= grant_id;
        winner  <= grant_id;
        MC_Op   <= grant_id ? Op1 : Op0;
        MC_A    <= grant_id ? A1 : A0;
        MC_B    <= grant_id ? B1 : B0;
        tmo_cnt <= '0;
      end else if ((state == LAUNCH || state == WAIT) && tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end

      if (finish) begin
        Result1 <= MC_Result1;
        Result2 <= MC_Result2;
      end else if (abort) begin
        Result1 <= '0;
        Result2 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Directed scenarios plus a randomized run scored against a cycle-level request/grant model.
module tb_mcycle_arbiter;

  localparam int W   = 4;
  localparam int TMO = 64;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic Req0 = 1'b0, Req1 = 1'b0;
  logic [1:0] Op0 = '0, Op1 = '0;
  logic [W-1:0] A0 = '0, A1 = '0, B0 = '0, B1 = '0;
  logic Ack0, Ack1, Done0, Done1, Err, MC_Start, MC_Busy;
  logic [1:0] MC_Op;
  logic [W-1:0] Result1, Result2, MC_A, MC_B, MC_Result1, MC_Result2;

  int mc_lat = 0;
  logic hang = 1'b0;
  int mc_cnt;
  logic [2*W-1:0] mc_res;

  int n_pass = 0, n_fail = 0, n_tot = 0;
  int cyc_n = 0, ack_cyc = 0, done_cyc = 0, start_cnt = 0;

  logic r_req[2];
  logic [1:0] r_op[2];
  logic [W-1:0] r_a[2], r_b[2];
  int free_from, last, w, cur_w, exp_done, n_ops;
  logic busy_m;
  logic [1:0] ea, ed;
  logic [2*W-1:0] exp_res;

  always #5 CLK = ~CLK;

  mcycle_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
    .A0(A0), .A1(A1), .B0(B0), .B1(B1),
    .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1), .Err(Err),
    .Result1(Result1), .Result2(Result2),
    .MC_Start(MC_Start), .MC_Op(MC_Op), .MC_A(MC_A), .MC_B(MC_B),
    .MC_Result1(MC_Result1), .MC_Result2(MC_Result2), .MC_Busy(MC_Busy)
  );

  // Arithmetic meaning of each op: {Result2, Result1}
  function automatic logic [2*W-1:0] mc_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, p, q, r;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    case (op)
      2'b00: begin p = sa * sb; return (2*W)'(p); end
      2'b01: begin p = int'(a) * int'(b); return (2*W)'(p); end
      2'b10: begin q = sa / sb; r = sa % sb; return {W'(r), W'(q)}; end
      default: begin q = int'(a) / int'(b); r = int'(a) % int'(b); return {W'(r), W'(q)}; end
    endcase
  endfunction

  // MCycle stand-in: Busy combinational from Start, then mc_lat more busy cycles.
  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mc_cnt <= 0;
      mc_res <= '0;
    end else if (MC_Start && mc_cnt == 0) begin
      mc_cnt <= mc_lat;
      mc_res <= mc_model(MC_Op, MC_A, MC_B);
    end else if (mc_cnt != 0) begin
      mc_cnt <= mc_cnt - 1;
    end
  end
  assign MC_Busy    = hang | MC_Start | (mc_cnt != 0);
  assign MC_Result1 = mc_res[W-1:0];
  assign MC_Result2 = mc_res[2*W-1:W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc_n++;
  endtask

  function automatic logic [31:0] outs();
    return {8'h0, Ack0, Ack1, Done0, Done1, Err, MC_Start, MC_Op, Result1, Result2, MC_A, MC_B};
  endfunction

  task automatic wait_ack(input int id, input string tag);
    int k = 0;
    do begin tick(); k++; end while (!(Ack0 | Ack1) && k < 200);
    chk($sformatf("%s_ack", tag), {Ack1, Ack0}, (id == 1) ? 2'b10 : 2'b01);
    ack_cyc   = cyc_n;
    start_cnt = int'(MC_Start);
  endtask

  task automatic wait_done(input int id, input logic [W-1:0] r1, input logic [W-1:0] r2,
                           input logic err, input int lat, input string tag);
    int k = 0;
    logic seen_ack = 1'b0;
    do begin
      tick(); k++;
      start_cnt += int'(MC_Start);
      if (Ack0 | Ack1) seen_ack = 1'b1;
    end while (!(Done0 | Done1) && k < 300);
    chk($sformatf("%s_done", tag), {Err, Done1, Done0}, {err, id == 1, id == 0});
    chk($sformatf("%s_r1", tag), Result1, r1);
    chk($sformatf("%s_r2", tag), Result2, r2);
    chk($sformatf("%s_lat", tag), cyc_n - ack_cyc, lat);
    chk($sformatf("%s_starts", tag), start_cnt, 1);
    chk($sformatf("%s_noack", tag), seen_ack, 1'b0);
    done_cyc = cyc_n;
    tick();
    chk($sformatf("%s_pulse", tag), {Ack1, Ack0, Err, Done1, Done0}, 5'b0);
  endtask

  task automatic new_opnds(input int i);
    r_op[i] = 2'($urandom_range(0, 3));
    r_a[i]  = W'($urandom);
    r_b[i]  = W'($urandom_range(1, (1 << W) - 1));
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_outs", outs(), 32'h0);

    // 1: single requester, smul -1 * -1
    RESETn = 1'b1;
    Req0 = 1'b1; Op0 = 2'b00; A0 = 4'hF; B0 = 4'hF;
    wait_ack(0, "t1");
    chk("t1_mc_opnds", {MC_Op, MC_A, MC_B}, {2'b00, 4'hF, 4'hF});
    Req0 = 1'b0;
    wait_done(0, 4'h1, 4'h0, 1'b0, mc_lat + 2, "t1");

    // 2: simultaneous requests after reset, requester 0 first
    RESETn = 1'b0; tick();
    RESETn = 1'b1;
    Req0 = 1'b1; Op0 = 2'b01; A0 = 4'h2; B0 = 4'h6;
    Req1 = 1'b1; Op1 = 2'b11; A1 = 4'h8; B1 = 4'h4;
    wait_ack(0, "t2a");
    Req0 = 1'b0;
    wait_done(0, 4'hC, 4'h0, 1'b0, mc_lat + 2, "t2a");
    wait_ack(1, "t2b");
    chk("t2_spacing", ack_cyc - done_cyc, 2);
    Req1 = 1'b0;
    wait_done(1, 4'h2, 4'h0, 1'b0, mc_lat + 2, "t2b");

    // 3: both held high, grants alternate
    Req0 = 1'b1; Op0 = 2'b01; A0 = 4'h3; B0 = 4'h3;
    Req1 = 1'b1; Op1 = 2'b11; A1 = 4'hF; B1 = 4'h2;
    for (int i = 0; i < 4; i++) begin
      mc_lat = i;
      wait_ack(i % 2, $sformatf("t3_%0d", i));
      if (i > 0) chk($sformatf("t3_spacing_%0d", i), ack_cyc - done_cyc, 2);
      if (i == 3) begin Req0 = 1'b0; Req1 = 1'b0; end
      if (i % 2 == 0) wait_done(0, 4'h9, 4'h0, 1'b0, mc_lat + 2, $sformatf("t3_%0d", i));
      else            wait_done(1, 4'h7, 4'h1, 1'b0, mc_lat + 2, $sformatf("t3_%0d", i));
    end

    // 4: Req1 raised while Req0's op is in WAIT
    mc_lat = 5;
    Req0 = 1'b1; Op0 = 2'b01; A0 = 4'h3; B0 = 4'h5;
    wait_ack(0, "t4a");
    Req0 = 1'b0;
    tick(); tick();
    Req1 = 1'b1; Op1 = 2'b10; A1 = 4'hC; B1 = 4'h3;
    wait_done(0, 4'hF, 4'h0, 1'b0, mc_lat + 2, "t4a");
    wait_ack(1, "t4b");
    chk("t4_first_idle", ack_cyc - done_cyc, 2);
    Req1 = 1'b0;
    wait_done(1, 4'hF, 4'hF, 1'b0, mc_lat + 2, "t4b");

    // 5: reset during WAIT, held Req0 re-granted afterwards
    mc_lat = 6;
    Req0 = 1'b1; Op0 = 2'b00; A0 = 4'h3; B0 = 4'hE;
    wait_ack(0, "t5a");
    tick(); tick();
    RESETn = 1'b0;
    #1;
    chk("t5_rst_now", outs(), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_rst_hold_%0d", i), outs(), 32'h0);
    end
    RESETn = 1'b1;
    wait_ack(0, "t5b");
    Req0 = 1'b0;
    wait_done(0, 4'hA, 4'hF, 1'b0, mc_lat + 2, "t5b");

    // 6: MCycle stuck busy, timeout abort
    hang = 1'b1;
    Req0 = 1'b1; Op0 = 2'b01; A0 = 4'h1; B0 = 4'h1;
    wait_ack(0, "t6");
    Req0 = 1'b0;
    wait_done(0, 4'h0, 4'h0, 1'b1, TMO, "t6");
    hang = 1'b0;
    mc_lat = 0;
    Req1 = 1'b1; Op1 = 2'b11; A1 = 4'h9; B1 = 4'h2;
    wait_ack(1, "t6b");
    Req1 = 1'b0;
    wait_done(1, 4'h4, 4'h1, 1'b0, mc_lat + 2, "t6b");

    // Randomized traffic against the request/grant model
    RESETn = 1'b0; tick();
    RESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin r_req[i] = 1'b0; new_opnds(i); end
    free_from = cyc_n + 1; last = 1; busy_m = 1'b0; n_ops = 0; cur_w = 0; exp_done = 0;
    exp_res = '0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      ed = 2'b00;
      if (busy_m && cyc_n == exp_done) ed = (cur_w == 1) ? 2'b10 : 2'b01;
      chk("rnd_done", {Err, Done1, Done0}, {1'b0, ed});
      if (ed != 2'b00) begin
        chk("rnd_res", {Result2, Result1}, exp_res);
        busy_m = 1'b0; free_from = cyc_n + 2; n_ops++;
      end

      ea = 2'b00;
      w  = 0;
      if (!busy_m && cyc_n >= free_from && (r_req[0] || r_req[1])) begin
        w  = (r_req[0] && r_req[1]) ? 1 - last : (r_req[1] ? 1 : 0);
        ea = (w == 1) ? 2'b10 : 2'b01;
      end
      chk("rnd_ack", {Ack1, Ack0}, ea);

      for (int i = 0; i < 2; i++) begin
        if (ea != 2'b00 && i == w) begin
          busy_m = 1'b1; cur_w = w; last = w;
          exp_res  = mc_model(r_op[i], r_a[i], r_b[i]);
          mc_lat   = $urandom_range(0, 4);
          exp_done = cyc_n + mc_lat + 2;
          r_req[i] = ($urandom_range(0, 1) == 1);
          new_opnds(i);
        end else if (r_req[i]) begin
          if ($urandom_range(0, 9) == 0) r_req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r_req[i] = 1'b1;
          new_opnds(i);
        end
      end
      Req0 = r_req[0]; Op0 = r_op[0]; A0 = r_a[0]; B0 = r_b[0];
      Req1 = r_req[1]; Op1 = r_op[1]; A1 = r_a[1]; B1 = r_b[1];
    end
    chk("rnd_ops_min", n_ops >= 20, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
